// File: rtl/instruction_loader.sv
// Boot-time loader: receives a length-prefixed big-endian byte stream and writes
// 32-bit words into instruction memory, holding the CPU until the program is in place.
module instruction_loader #(
  parameter int WORDS = 9,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_run,
  output logic        load_done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(WORDS);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] n_reg;
  logic [CNT_W-1:0] word_idx_reg;
  logic [1:0]       byte_cnt_reg;
  logic [31:0]      asm_reg;
  logic             xfer;
  logic [CNT_W-1:0] n_full;

  assign xfer   = rx_valid && rx_ready;
  // Header value as it will be once the low byte on the bus is latched.
  assign n_full = CNT_W'({n_reg[15:8], rx_data});

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (start) state_next = HDR_HI;
      HDR_HI: if (xfer) state_next = HDR_LO;
      HDR_LO: begin
        if (xfer) begin
          if (n_full == '0)        state_next = DONE;
          else if (n_full > MAX_N) state_next = ERR;
          else                     state_next = DATA;
        end
      end
      DATA:   if (xfer && byte_cnt_reg == 2'd3) state_next = WRITE;
      WRITE: begin
        if (word_idx_reg == n_reg - CNT_W'(1)) state_next = DONE;
        else                                   state_next = DATA;
      end
      DONE:   if (start) state_next = HDR_HI;
      ERR:    state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  // Every output is a pure decode of the current state and registered datapath.
  always_comb begin
    rx_ready   = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = 32'd0;
    imem_wdata = 32'd0;
    cpu_run    = 1'b0;
    load_done  = 1'b0;
    err        = 1'b0;
    case (state_reg)
      HDR_HI, HDR_LO, DATA: rx_ready = 1'b1;
      WRITE: begin
        imem_we    = 1'b1;
        imem_addr  = 32'(word_idx_reg) << 2;
        imem_wdata = asm_reg;
      end
      DONE: begin
        cpu_run   = 1'b1;
        load_done = 1'b1;
      end
      ERR: err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg        <= '0;
      word_idx_reg <= '0;
      byte_cnt_reg <= '0;
      asm_reg      <= '0;
    end else begin
      case (state_reg)
        HDR_HI: if (xfer) n_reg <= CNT_W'({rx_data, 8'h00});
        HDR_LO: begin
          if (xfer) begin
            n_reg        <= n_full;
            word_idx_reg <= '0;
            byte_cnt_reg <= '0;
          end
        end
        DATA: begin
          if (xfer) begin
            asm_reg      <= {asm_reg[23:0], rx_data};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
          end
        end
        WRITE: begin
          word_idx_reg <= word_idx_reg + CNT_W'(1);
          byte_cnt_reg <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: drives byte streams at negedges and
// checks the write log, handshake and status outputs against hand-computed values.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic        load_done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Write log and protocol-violation counters, owned by the negedge monitor.
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          wr_cnt = 0;
  int          multi_we = 0;
  int          ready_in_write = 0;
  logic        we_prev = 1'b0;

  instruction_loader #(.WORDS(9), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .load_done  (load_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = imem_addr;
        wr_data[wr_cnt] = imem_wdata;
      end
      wr_cnt = wr_cnt + 1;
      if (we_prev) multi_we = multi_we + 1;
      if (rx_ready) ready_in_write = ready_in_write + 1;
    end
    we_prev = imem_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks below start and end at a negedge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) begin
      rx_valid = 1'b0;
      rx_data  = 8'h5A;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic pulse_start(output int start_cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(output int done_cyc);
    int n = 0;
    rx_valid = 1'b0;
    while (!load_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!load_done) check("load_done_timeout", 32'd0, 32'd1);
    done_cyc = cyc;
  endtask

  task automatic apply_reset();
    rx_valid = 1'b0;
    start    = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_rx_ready"},   {31'd0, rx_ready},  32'd0);
    check({pfx, "_imem_we"},    {31'd0, imem_we},   32'd0);
    check({pfx, "_imem_addr"},  imem_addr,          32'd0);
    check({pfx, "_imem_wdata"}, imem_wdata,         32'd0);
    check({pfx, "_cpu_run"},    {31'd0, cpu_run},   32'd0);
    check({pfx, "_load_done"},  {31'd0, load_done}, 32'd0);
    check({pfx, "_err"},        {31'd0, err},       32'd0);
  endtask

  task automatic basic_load(input string pfx, input bit gap);
    int base, sc, dc;
    base = wr_cnt;
    pulse_start(sc);
    send_byte(8'h00, gap);
    send_byte(8'h02, gap);
    send_word(32'h2008_0005, gap);
    send_word(32'h0000_0008, gap);
    wait_done(dc);
    check({pfx, "_nwrites"}, 32'(wr_cnt - base), 32'd2);
    check({pfx, "_addr0"},   wr_addr[base],      32'h0000_0000);
    check({pfx, "_data0"},   wr_data[base],      32'h2008_0005);
    check({pfx, "_addr1"},   wr_addr[base+1],    32'h0000_0004);
    check({pfx, "_data1"},   wr_data[base+1],    32'h0000_0008);
    check({pfx, "_cpu_run"}, {31'd0, cpu_run},   32'd1);
    if (!gap) check({pfx, "_latency"}, 32'(dc - sc), 32'd12);
  endtask

  initial begin
    int base, sc, dc;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    $display("reset: outputs checked");

    // Basic continuous load
    basic_load("basic", 1'b0);
    check("basic_single_we", 32'(multi_we), 32'd0);
    $display("basic load: 2 words, done at +12 cycles expected");

    // Backpressure gaps
    apply_reset();
    basic_load("gap", 1'b1);
    check("gap_ready_in_write", 32'(ready_in_write), 32'd0);
    check("gap_single_we", 32'(multi_we), 32'd0);
    $display("gap load: alternate-cycle rx_valid");

    // Oversize header
    apply_reset();
    base = wr_cnt;
    pulse_start(sc);
    send_byte(8'h00, 1'b0);
    send_byte(8'h0A, 1'b0);
    check("over_err", {31'd0, err}, 32'd1);
    rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    pulse_start(sc);
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    check("over_err_hold", {31'd0, err},      32'd1);
    check("over_ready",    {31'd0, rx_ready}, 32'd0);
    check("over_cpu_run",  {31'd0, cpu_run},  32'd0);
    check("over_nwrites",  32'(wr_cnt - base), 32'd0);
    $display("oversize header: N=10 against capacity 9");

    // Exactly-capacity load (N == WORDS) must be accepted
    apply_reset();
    base = wr_cnt;
    pulse_start(sc);
    send_byte(8'h00, 1'b0);
    send_byte(8'h09, 1'b0);
    for (int i = 0; i < 9; i++) send_word(32'h1000_0000 + 32'(i), 1'b0);
    wait_done(dc);
    check("full_err",      {31'd0, err},      32'd0);
    check("full_nwrites",  32'(wr_cnt - base), 32'd9);
    check("full_last_addr", wr_addr[base+8],  32'h0000_0020);
    check("full_last_data", wr_data[base+8],  32'h1000_0008);
    check("full_latency",   32'(dc - sc),     32'd47);
    $display("capacity load: 9 words");

    // Zero-length load
    apply_reset();
    base = wr_cnt;
    pulse_start(sc);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    rx_valid = 1'b0;
    check("zero_load_done", {31'd0, load_done}, 32'd1);
    check("zero_cpu_run",   {31'd0, cpu_run},   32'd1);
    check("zero_nwrites",   32'(wr_cnt - base),  32'd0);
    $display("zero-length load");

    // Reset mid-word, then a clean load
    apply_reset();
    base = wr_cnt;
    pulse_start(sc);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h08, 1'b0);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    check("midrst_nwrites", 32'(wr_cnt - base), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    basic_load("after_rst", 1'b0);
    $display("reset mid-word then reload");

    // Reload from DONE
    base = wr_cnt;
    pulse_start(sc);
    check("reload_cpu_run_low",   {31'd0, cpu_run},   32'd0);
    check("reload_load_done_low", {31'd0, load_done}, 32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    wait_done(dc);
    check("reload_nwrites", 32'(wr_cnt - base), 32'd1);
    check("reload_addr",    wr_addr[base],      32'h0000_0000);
    check("reload_data",    wr_data[base],      32'hDEAD_BEEF);
    check("reload_cpu_run", {31'd0, cpu_run},   32'd1);
    check("reload_latency", 32'(dc - sc),       32'd7);
    $display("reload from DONE: 1 word");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time program loader sitting directly upstream of the single-cycle processor's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into instruction memory at consecutive word addresses. It holds the processor out of execution (`cpu_run` low) until the whole program is loaded. This replaces the fixed file preload with a runtime load path.

## Interface
Parameters:
- `WORDS`, 9: instruction memory capacity in 32-bit words. This is the maximum program length accepted.
- `CNT_W`, 16: width of the word-count header field.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle request to begin a load.
- `rx_valid`  in  1  upstream byte is present.
- `rx_data`  in  8  upstream byte.
- `rx_ready`  out  1  loader can accept a byte this cycle.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_addr`  out  32  byte address of the word being written. Always a multiple of 4; the memory indexes by `imem_addr>>2`.
- `imem_wdata`  out  32  assembled instruction word.
- `cpu_run`  out  1  processor may advance the PC. Gates PC update and register-file/data-memory writes.
- `load_done`  out  1  program fully written.
- `err`  out  1  header word count exceeded `WORDS`.

## Operation
- Stream format:
  - 2 header bytes give word count N, high byte first.
  - These are followed by N×4 data bytes. Each word arrives MSB first: `word = {b0,b1,b2,b3}`.
- Byte transfer: a byte is consumed on a posedge where `rx_valid && rx_ready`. `rx_data` is ignored otherwise.
- States:
  - IDLE: `rx_ready=0`. Moves to HDR_HI on `start`.
  - HDR_HI: `rx_ready=1`. On transfer, latches `N[15:8]` and moves to HDR_LO.
  - HDR_LO: `rx_ready=1`. On transfer, latches `N[7:0]` and clears word_idx and byte_cnt. Next state is DONE if N==0, ERR if N>WORDS, otherwise DATA.
  - DATA: `rx_ready=1`. On transfer, shifts the byte into the 32-bit assembly register: `asm = {asm[23:0], rx_data}`. byte_cnt increments. On the 4th byte (byte_cnt==3) it moves to WRITE.
  - WRITE: `rx_ready=0`, `imem_we=1`, `imem_addr=word_idx<<2`, `imem_wdata=asm`. Lasts exactly one cycle. word_idx increments. Next state is DONE if word_idx==N-1, otherwise DATA with byte_cnt=0.
  - DONE: `load_done=1`, `cpu_run=1`, `rx_ready=0`. On `start`, clears `load_done` and `cpu_run` and moves to HDR_HI (reload).
  - ERR: `err=1`, `rx_ready=0`, `cpu_run=0`. No memory writes occur. Only `rst` exits this state.
- `start` is ignored in HDR_HI, HDR_LO, DATA, WRITE and ERR.
- A stalled `rx_valid` (low) in any receive state holds all state. There is no timeout.
- N is compared as an unsigned `CNT_W`-bit value. word_idx and byte_cnt never wrap within a legal load.

## Timing
- Reset values:
  - state is IDLE.
  - `rx_ready`, `imem_we`, `cpu_run`, `load_done` and `err` are 0.
  - `imem_addr` and `imem_wdata` are 0.
  - Internal N, word_idx, byte_cnt and asm are 0.
- Reset mid-load: returns to IDLE on the next posedge and discards any partial word. Words already written stay in memory; the loader does not clear them.
- `rst` has priority over `start` and `rx_valid` in the same cycle.
- Write latency: when the 4th byte of a word is accepted at edge k, `imem_we` is high during cycle k+1 and the memory captures the word at edge k+2.
- Output timing: all outputs are registered or decoded from state only. There is no combinational path from `rx_valid` to `rx_ready`.
- Completion: `cpu_run` rises in the cycle after the last WRITE cycle. A loaded N-word program needs 2 + 5N cycles of continuous `rx_valid` after `start`.
- Reload: `cpu_run` falls in the cycle after `start` is sampled in DONE. The processor sees no instruction fetch progress during the reload.

## Test plan
- Basic load:
  - Stimulus: reset, then `start`, then bytes 00 02 | 20 08 00 05 | 00 00 00 08 with `rx_valid` held high.
  - Required: writes of (addr 0, 0x20080005) and (addr 4, 0x00000008), each with a single-cycle `imem_we`. `cpu_run` and `load_done` go to 1 exactly 12 cycles after `start`.
- Backpressure gaps:
  - Stimulus: the same stream with `rx_valid` low on alternate cycles.
  - Required: identical writes and data. `rx_ready` is 0 during each WRITE cycle, and no byte is consumed in that cycle.
- Oversize header:
  - Stimulus: header 00 0A with `WORDS`=9.
  - Required: `err`=1 and `imem_we` never asserts. The state persists until `rst`.
- Zero-length load:
  - Stimulus: header 00 00.
  - Required: `load_done`=1 and `cpu_run`=1 one cycle after the 2nd header byte, with no writes.
- Reset mid-word:
  - Stimulus: assert `rst` after 2 data bytes of word 1.
  - Required: all outputs are 0 next cycle, with no write of the partial word. A following full load then succeeds.
- Reload from DONE:
  - Stimulus: `start` pulse while in DONE, followed by a 1-word stream DE AD BE EF.
  - Required: `cpu_run` drops to 0, then one write (addr 0, 0xDEADBEEF), then `cpu_run` returns to 1.
